// File: rtl/hkspi_seq.sv
// rtl/hkspi_seq.sv - Command-driven SPI master sequencer for the housekeeping SPI slave
// Optional feature macro: HKSPI_SEQ_CLKDIV_EN adds a per-transaction SCK half-period port (clkdiv)
module hkspi_seq #(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clock,
  input  logic       reset,
`ifdef HKSPI_SEQ_CLKDIV_EN
  input  logic [7:0] clkdiv,
`endif
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [4:0] cmd_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       spi_csb,
  output logic       spi_sck,
  output logic       spi_sdi,
  input  logic       spi_sdo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_FETCH,
    S_HOLD,
    S_GAP
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       r_write;
  logic [7:0] r_addr;
  logic [4:0] r_len;
  logic [8:0] r_cnt;       // cycles elapsed in the current SCK phase / wait window
  logic [2:0] r_bit;       // bit index within the current byte, 7 first
  logic [5:0] r_byte;      // 0 = command byte, 1 = address, 2.. = data
  logic [7:0] r_shift;     // outgoing byte, MSB drives SDI
  logic [7:0] r_rx;
  logic       r_rx_full;   // a complete read byte is waiting to be strobed out
  logic [7:0] r_rd_data;
  logic       r_rd_valid;
  logic       r_done;
  logic       r_csb;
  logic       r_sck;

  logic [7:0] w_h;
  logic [8:0] w_h_last;
  logic [8:0] w_gap_last;
  logic       w_cnt_end;
  logic       w_gap_end;
  logic       w_bit_end;
  logic       w_byte_end;
  logic       w_last_byte;
  logic       w_rd_byte;

`ifdef HKSPI_SEQ_CLKDIV_EN
  logic [7:0] r_h;
  assign w_h = r_h;
`else
  assign w_h = 8'(HALF_PERIOD);
`endif

  assign w_h_last    = {1'b0, w_h} - 9'd1;
  assign w_gap_last  = {w_h, 1'b0} - 9'd1;
  assign w_cnt_end   = (r_cnt == w_h_last);
  assign w_gap_end   = (r_cnt == w_gap_last);
  assign w_bit_end   = (r_state == S_SHIFT) && r_sck && w_cnt_end;
  assign w_byte_end  = w_bit_end && (r_bit == 3'd0);
  assign w_last_byte = (r_byte == ({1'b0, r_len} + 6'd2));
  assign w_rd_byte   = !r_write && (r_byte >= 6'd2);

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next = S_SETUP;
      end
      S_SETUP: if (w_cnt_end) w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_byte_end) begin
          if (w_last_byte)                      w_next = S_HOLD;
          else if (r_write && r_byte >= 6'd1)   w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        wr_ready = 1'b1;
        if (wr_valid) w_next = S_SHIFT;
      end
      S_HOLD:  if (w_cnt_end) w_next = S_GAP;
      S_GAP:   if (w_gap_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: command capture, SCK phase timing, shift registers and strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_addr     <= 8'h00;
      r_len      <= 5'd0;
      r_cnt      <= 9'd0;
      r_bit      <= 3'd7;
      r_byte     <= 6'd0;
      r_shift    <= 8'h00;
      r_rx       <= 8'h00;
      r_rx_full  <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_csb      <= 1'b1;
      r_sck      <= 1'b0;
`ifdef HKSPI_SEQ_CLKDIV_EN
      r_h        <= 8'd1;
`endif
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= r_rx_full;
      r_rx_full  <= 1'b0;
      if (r_rx_full) r_rd_data <= r_rx;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_write <= cmd_write;
            r_addr  <= cmd_addr;
            r_len   <= cmd_len;
            r_shift <= cmd_write ? 8'h80 : 8'h40;
            r_csb   <= 1'b0;
            r_sck   <= 1'b0;
            r_cnt   <= 9'd0;
            r_bit   <= 3'd7;
            r_byte  <= 6'd0;
`ifdef HKSPI_SEQ_CLKDIV_EN
            r_h     <= (clkdiv == 8'd0) ? 8'd1 : clkdiv;
`endif
          end
        end
        S_SETUP: r_cnt <= w_cnt_end ? 9'd0 : r_cnt + 9'd1;
        S_SHIFT: begin
          if (!w_cnt_end) begin
            r_cnt <= r_cnt + 9'd1;
          end else begin
            r_cnt <= 9'd0;
            if (!r_sck) begin
              r_sck <= 1'b1;
            end else begin
              // Falling edge: next bit starts its low phase with new SDI
              r_sck <= 1'b0;
              r_bit <= r_bit - 3'd1;
              if (r_bit != 3'd0) begin
                r_shift <= {r_shift[6:0], 1'b0};
              end else begin
                r_byte  <= r_byte + 6'd1;
                r_shift <= (r_byte == 6'd0) ? r_addr : 8'h00;
              end
            end
          end
          // Slave output is sampled during the first high cycle of each read bit
          if (r_sck && r_cnt == 9'd0 && w_rd_byte) begin
            r_rx <= {r_rx[6:0], spi_sdo};
            if (r_bit == 3'd0) r_rx_full <= 1'b1;
          end
        end
        S_FETCH: begin
          // The fetch cycle doubles as the first low cycle of the data byte,
          // so an unstalled fetch costs no extra time.
          if (wr_valid) begin
            r_shift <= wr_data;
            r_cnt   <= w_cnt_end ? 9'd0 : r_cnt + 9'd1;
            if (w_cnt_end) r_sck <= 1'b1;
          end
        end
        S_HOLD: begin
          r_cnt <= w_cnt_end ? 9'd0 : r_cnt + 9'd1;
          if (w_cnt_end) r_csb <= 1'b1;
        end
        S_GAP: begin
          r_cnt <= w_gap_end ? 9'd0 : r_cnt + 9'd1;
          if (w_gap_end) r_done <= 1'b1;
        end
        default: r_cnt <= 9'd0;
      endcase
    end
  end

  assign spi_csb  = r_csb;
  assign spi_sck  = r_sck;
  assign spi_sdi  = (r_state == S_FETCH) ? wr_data[7] : r_shift[7];
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign done     = r_done;

endmodule

// File: tb/tb_hkspi_seq.sv
// tb/tb_hkspi_seq.sv - Self-checking bench for hkspi_seq with a behavioural housekeeping SPI slave
module tb_hkspi_seq;
  localparam int HP = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [4:0] cmd_len = 5'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       cmd_ready, wr_ready, rd_valid, busy, done;
  logic [7:0] rd_data;
  logic       spi_csb, spi_sck, spi_sdi;
  logic       spi_sdo = 1'b0;
`ifdef HKSPI_SEQ_CLKDIV_EN
  logic [7:0] clkdiv = 8'd2;
`endif

  hkspi_seq #(.HALF_PERIOD(HP)) dut (
    .clock(clock), .reset(reset),
`ifdef HKSPI_SEQ_CLKDIV_EN
    .clkdiv(clkdiv),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int h_cur = HP;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Housekeeping register file contents at power-up
  function automatic logic [7:0] init_reg(input int i);
    case (i)
      0: return 8'h00;  1: return 8'h04;  2: return 8'h56;  3: return 8'h10;
      4: return 8'h02;  8: return 8'h01; 18: return 8'h04;
      default: return (i < 19) ? 8'h00 : 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  // Behavioural SPI mode-0 slave: command, address, then auto-incrementing data
  logic [7:0] sl_regs [0:255];
  logic [7:0] sl_sr = 8'h00, sl_cmd = 8'h00, sl_addr = 8'h00, sl_tx = 8'h00;
  int         sl_bits = 0;
  logic [7:0] sl_bytes [$];

  always @(negedge spi_csb) begin
    sl_bits = 0;
    sl_cmd  = 8'h00;
    sl_bytes.delete();
  end

  always @(posedge spi_sck) if (!spi_csb) begin
    sl_sr = {sl_sr[6:0], spi_sdi};
    sl_bits++;
    if (sl_bits % 8 == 0) begin
      sl_bytes.push_back(sl_sr);
      if (sl_bits == 8)       sl_cmd = sl_sr;
      else if (sl_bits == 16) sl_addr = sl_sr;
      else if (sl_cmd == 8'h80) begin
        sl_regs[sl_addr] = sl_sr;
        sl_addr++;
      end
    end
  end

  always @(negedge spi_sck) if (!spi_csb && sl_cmd == 8'h40 && sl_bits >= 16) begin
    if (sl_bits % 8 == 0) begin
      sl_tx = sl_regs[sl_addr];
      sl_addr++;
    end else begin
      sl_tx = {sl_tx[6:0], 1'b0};
    end
    spi_sdo = sl_tx[7];
  end

  // Waveform monitor: SCK high-phase lengths, SDI stability while SCK high, CSB releases
  logic prev_sck = 1'b0, prev_sdi = 1'b0, prev_csb = 1'b1;
  int   hi_run = 0, hi_min = 1000, hi_max = 0, sdi_viol = 0, csb_rises = 0;

  always @(negedge clock) begin
    if (spi_sck) hi_run++;
    else if (prev_sck) begin
      if (hi_run < hi_min) hi_min = hi_run;
      if (hi_run > hi_max) hi_max = hi_run;
      hi_run = 0;
    end
    if (prev_sck && spi_sck && spi_sdi !== prev_sdi) sdi_viol++;
    if (!prev_csb && spi_csb) csb_rises++;
    prev_sck = spi_sck;
    prev_sdi = spi_sdi;
    prev_csb = spi_csb;
  end

  // Reference register file: what the slave must hold after every write
  logic [7:0] ref_regs [0:255];
  logic [7:0] txd [0:31];
  logic [7:0] got [$];

  task automatic run_txn(input bit wr, input logic [7:0] addr, input int nb,
                         input int stall_idx, input int stall_cyc, input int exp_cyc,
                         input string tag);
    int t0, dur, idx, stall_left, guard, stall_bad;
    bit seen_done;
    got.delete();
    dur = -1;
    @(negedge clock);
    chk($sformatf("%s cmd_ready", tag), 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = 5'(nb - 1);
    @(posedge clock);
    #1;
    t0 = cyc;
    hi_run = 0; hi_min = 1000; hi_max = 0; csb_rises = 0;
    // Scrambled command fields held valid while busy must be ignored
    cmd_write = ~wr;
    cmd_addr  = ~addr;
    cmd_len   = ~cmd_len;
    idx = 0; stall_left = stall_cyc; seen_done = 1'b0; guard = 0; stall_bad = 0;
    while (!seen_done && guard < 20000) begin
      @(negedge clock);
      guard++;
      if (cyc - t0 >= 8) cmd_valid = 1'b0;
      if (rd_valid) got.push_back(rd_data);
      if (done) begin
        seen_done = 1'b1;
        dur = cyc - t0;
      end
      if (wr_ready) begin
        if (idx == stall_idx && stall_left > 0) begin
          wr_valid = 1'b0;
          stall_left--;
          if (spi_sck || spi_csb) stall_bad++;
        end else begin
          wr_valid = 1'b1;
          wr_data  = txd[idx];
          idx++;
        end
      end else begin
        wr_valid = 1'b0;
      end
    end
    wr_valid  = 1'b0;
    cmd_valid = 1'b0;
    chk($sformatf("%s done seen", tag), 32'(seen_done), 1);
    chk($sformatf("%s duration", tag), dur, exp_cyc);
    chk($sformatf("%s sck high min", tag), hi_min, h_cur);
    chk($sformatf("%s sck high max", tag), hi_max, h_cur);
    chk($sformatf("%s csb single release", tag), csb_rises, 1);
    chk($sformatf("%s stall sck/csb low", tag), stall_bad, 0);
    chk($sformatf("%s idle after done", tag), {30'd0, busy, spi_csb}, 32'd1);
    chk($sformatf("%s sdi byte count", tag), sl_bytes.size(), nb + 2);
    if (sl_bytes.size() >= 2) begin
      chk($sformatf("%s cmd byte", tag), 32'(sl_bytes[0]), wr ? 32'h80 : 32'h40);
      chk($sformatf("%s addr byte", tag), 32'(sl_bytes[1]), 32'(addr));
    end
    if (wr) begin
      for (int i = 0; i < nb; i++) begin
        if (sl_bytes.size() > i + 2)
          chk($sformatf("%s wr byte %0d", tag, i), 32'(sl_bytes[i + 2]), 32'(txd[i]));
        ref_regs[8'(int'(addr) + i)] = txd[i];
      end
    end else begin
      chk($sformatf("%s rd count", tag), got.size(), nb);
      for (int i = 0; i < nb && i < got.size(); i++)
        chk($sformatf("%s rd byte %0d", tag, i), 32'(got[i]), 32'(ref_regs[8'(int'(addr) + i)]));
    end
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    int         nb;
    logic [7:0] d0, d1, d2;
    int         stall_idx;
    int         stall_cyc;
    int         exp_cyc;
    logic [7:0] exp_first;
  } vec_t;

  vec_t vecs [0:7];

  initial begin
    int guard, nb, st, exp_c, dn;
    bit wr;
    logic [7:0] a;

    for (int i = 0; i < 256; i++) begin
      sl_regs[i]  = init_reg(i);
      ref_regs[i] = init_reg(i);
    end

    //          wr    addr   nb  d0     d1     d2     sidx scyc exp  first
    vecs[0] = '{1'b0, 8'h03, 1,  8'h00, 8'h00, 8'h00, -1,  0,   104, 8'h10};
    vecs[1] = '{1'b1, 8'h0b, 1,  8'h01, 8'h00, 8'h00, -1,  0,   104, 8'h00};
    vecs[2] = '{1'b0, 8'h0b, 1,  8'h00, 8'h00, 8'h00, -1,  0,   104, 8'h01};
    vecs[3] = '{1'b1, 8'h0b, 1,  8'h00, 8'h00, 8'h00, -1,  0,   104, 8'h00};
    vecs[4] = '{1'b0, 8'h0b, 1,  8'h00, 8'h00, 8'h00, -1,  0,   104, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 19, 8'h00, 8'h00, 8'h00, -1,  0,   680, 8'h00};
    vecs[6] = '{1'b1, 8'h20, 3,  8'hA5, 8'h5A, 8'hC3, 1,   100, 268, 8'h00};
    vecs[7] = '{1'b0, 8'h20, 3,  8'h00, 8'h00, 8'h00, -1,  0,   168, 8'hA5};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset csb", 32'(spi_csb), 1);
    chk("reset sck/sdi", {30'd0, spi_sck, spi_sdi}, 0);
    chk("reset busy/done/rd_valid/wr_ready", {28'd0, busy, done, rd_valid, wr_ready}, 0);
    chk("reset cmd_ready", 32'(cmd_ready), 1);
    chk("reset rd_data", 32'(rd_data), 0);
    reset = 1'b0;

    // Directed table
    for (int v = 0; v < 8; v++) begin
      txd[0] = vecs[v].d0; txd[1] = vecs[v].d1; txd[2] = vecs[v].d2;
      run_txn(vecs[v].wr, vecs[v].addr, vecs[v].nb, vecs[v].stall_idx,
              vecs[v].stall_cyc, vecs[v].exp_cyc, $sformatf("vec%0d", v));
      if (!vecs[v].wr && got.size() > 0)
        chk($sformatf("vec%0d first byte", v), 32'(got[0]), 32'(vecs[v].exp_first));
    end

    // Reset during the 4th bit of the address byte
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03; cmd_len = 5'd0;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    guard = 0;
    while (!(sl_bits == 11 && !spi_sck) && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    chk("abort reached addr bit 4", 32'(sl_bits == 11 && !spi_sck), 1);
    reset = 1'b1;
    dn = 0;
    @(negedge clock);
    chk("abort csb", 32'(spi_csb), 1);
    chk("abort sck/sdi", {30'd0, spi_sck, spi_sdi}, 0);
    chk("abort busy/done/rd_valid", {29'd0, busy, done, rd_valid}, 0);
    chk("abort cmd_ready", 32'(cmd_ready), 1);
    chk("abort rd_data", 32'(rd_data), 0);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done || rd_valid) dn++;
    end
    chk("abort no done/rd_valid", dn, 0);
    run_txn(1'b0, 8'h03, 1, -1, 0, 104, "post-abort read");
    if (got.size() > 0) chk("post-abort value", 32'(got[0]), 32'h10);

    // Randomized transactions against the reference register file
    for (int r = 0; r < 10; r++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      nb = $urandom_range(1, 6);
      st = wr ? $urandom_range(0, 5) : 0;
      for (int i = 0; i < nb; i++) txd[i] = 8'($urandom_range(0, 255));
      exp_c = (2 + nb) * 16 * h_cur + 4 * h_cur + st;
      run_txn(wr, a, nb, wr ? $urandom_range(0, nb - 1) : -1, st, exp_c, $sformatf("rand%0d", r));
    end

`ifdef HKSPI_SEQ_CLKDIV_EN
    clkdiv = 8'd5; h_cur = 5;
    run_txn(1'b0, 8'h03, 1, -1, 0, 3 * 16 * 5 + 4 * 5, "clkdiv5");
    clkdiv = 8'd0; h_cur = 1;
    run_txn(1'b0, 8'h03, 1, -1, 0, 3 * 16 + 4, "clkdiv0");
    clkdiv = 8'd2; h_cur = 2;
`endif

    chk("sdi stable while sck high", sdi_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hkspi_seq.md
HKSPI_SEQ -- requirements
Module: hkspi_seq

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 2, giving the SCK half-period in clock cycles when the divider feature is compiled out (legal 1..255).
REQ-002 SHALL have port clock  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write stream, 0=read stream), cmd_addr in 8 (start register), cmd_len in 5 (data bytes minus 1, so 1..32 bytes).
REQ-005 SHALL have ports wr_data in 8, wr_valid in 1, wr_ready out 1 for write payload bytes.
REQ-006 SHALL have ports rd_data out 8, rd_valid out 1 (single-cycle strobe, no backpressure).
REQ-007 SHALL have ports busy out 1 and done out 1 (single-cycle pulse at end of transaction).
REQ-008 SHALL have ports spi_csb out 1, spi_sck out 1, spi_sdi out 1, spi_sdo in 1 toward the housekeeping SPI slave.

Function
REQ-009 SHALL accept a command on the cycle cmd_valid and cmd_ready are both high; cmd_ready is high only in IDLE.
REQ-010 SHALL use states IDLE -> SETUP -> SHIFT -> (FETCH) -> HOLD -> GAP -> IDLE.
REQ-011 SHALL, in SETUP, drive spi_csb low on the cycle after acceptance and hold SCK low for H cycles (H = half-period).
REQ-012 SHALL send byte 0x80 (write) or 0x40 (read), then cmd_addr, then cmd_len+1 data bytes, all MSB first, without releasing spi_csb.
REQ-013 SHALL change spi_sdi only while spi_sck is low, at the start of each bit; each bit is H cycles low then H cycles high.
REQ-014 SHALL sample spi_sdo on the cycle spi_sck rises, during read data bytes only.
REQ-015 SHALL pulse rd_valid with the assembled byte one cycle after the 8th data-bit sample of each read byte.
REQ-016 SHALL, for write transactions, enter FETCH before each data byte, assert wr_ready there, and capture wr_data on wr_valid&&wr_ready.
REQ-017 SHALL, when wr_valid is low in FETCH, stall with spi_sck low and spi_csb low indefinitely, resuming on the first cycle wr_valid rises.
REQ-018 SHALL, in HOLD, keep spi_sck low for H cycles after the last falling edge, then raise spi_csb.
REQ-019 SHALL, in GAP, keep spi_csb high for 2H cycles, then pulse done and return to IDLE; busy is high in every state except IDLE.
REQ-020 SHALL ignore cmd_valid while busy; cmd_* is registered at acceptance and later changes have no effect.
REQ-021 SHALL make a transaction of N data bytes last exactly (2+N)*16H + 4H cycles from acceptance to done when no write stalls occur.

Reset
REQ-022 SHALL, on reset (including mid-transaction), on the next edge set state IDLE, spi_csb=1, spi_sck=0, spi_sdi=0, busy=0, done=0, rd_valid=0, wr_ready=0, cmd_ready=1, rd_data=0x00.
REQ-023 SHALL NOT pulse done or rd_valid for a transaction aborted by reset.

Configuration
REQ-024 SHALL, with macro HKSPI_SEQ_CLKDIV_EN defined, add input port clkdiv in 8, sampled at command acceptance, as H for that transaction, with 0 treated as 1.
REQ-025 SHALL, without HKSPI_SEQ_CLKDIV_EN, omit clkdiv and use H = HALF_PERIOD for all transactions.

Verification
REQ-026 Read, addr 0x03, cmd_len 0, slave returns 0x10 -> SDI bytes 0x40,0x03; one rd_valid with 0x10; done; spi_csb high.
REQ-027 Write, addr 0x0b, data 0x01 then write 0x00 -> SDI bytes 0x80,0x0b,0x01 and 0x80,0x0b,0x00; slave register 0x0b updates; done per transaction.
REQ-028 Read stream, addr 0x00, cmd_len 18, slave model regs 0..18 -> 19 rd_valid strobes in order (0x00,0x04,0x56,0x10,...,0x04); CSB low throughout; H=2 gives done at 21*32+8=680 cycles.
REQ-029 Write of 3 bytes with wr_valid withheld 100 cycles before byte 2 -> spi_csb stays low, spi_sck low for the stall, data 0xA5,0x5A,0xC3 arrive intact.
REQ-030 Reset asserted during 4th bit of addr byte -> next edge spi_csb=1, spi_sck=0, busy=0, no done; a following read of addr 0x03 returns 0x10.
REQ-031 With HKSPI_SEQ_CLKDIV_EN, clkdiv=5 -> SCK high and low phases each exactly 5 cycles; clkdiv=0 -> 1-cycle phases.
